// File: rtl/umi_gpio_pkg.sv
// Shared types, register-map constants and UMI packet helpers for the GPIO bank endpoint.
// Opcode values mirror umi_messages.vh so this slice elaborates stand-alone.
package umi_gpio_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } gpio_state_t;

    localparam int          REG_STRIDE = 16;
    localparam int          OUT_OFFSET = 0;
    localparam int          IN_OFFSET  = 8;
    localparam logic [15:0] ERR_MAX    = 16'hFFFF;

    localparam logic [7:0] UMI_WRITE_POSTED   = 8'h01;
    localparam logic [7:0] UMI_WRITE_RESPONSE = 8'h02;
    localparam logic [7:0] UMI_READ_REQUEST   = 8'h08;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [2:0]  size;
        logic [63:0] dstaddr;
        logic [63:0] srcaddr;
        logic [63:0] data;
    } umi_pkt_t;

    // Packet layout: [7:0] opcode, [10:8] size, [95:32] dstaddr, [159:96] srcaddr, [223:160] data.
    function automatic logic [255:0] umi_pack(input umi_pkt_t p);
        logic [255:0] pkt;
        pkt            = '0;
        pkt[7:0]       = p.opcode;
        pkt[10:8]      = p.size;
        pkt[95:32]     = p.dstaddr;
        pkt[159:96]    = p.srcaddr;
        pkt[223:160]   = p.data;
        return pkt;
    endfunction

    function automatic umi_pkt_t umi_unpack(input logic [255:0] pkt);
        umi_pkt_t p;
        p.opcode  = pkt[7:0];
        p.size    = pkt[10:8];
        p.dstaddr = pkt[95:32];
        p.srcaddr = pkt[159:96];
        p.data    = pkt[223:160];
        return p;
    endfunction

    // Bytes touched by a write of 2^size bytes, clamped to the register width.
    function automatic int umi_byte_count(input logic [2:0] size, input int max_bytes);
        int n;
        n = 1 << size;
        return (n > max_bytes) ? max_bytes : n;
    endfunction

endpackage

// File: rtl/umi_gpio_decode.sv
// Combinational address/opcode decode for the GPIO bank register window.
import umi_gpio_pkg::*;

module umi_gpio_decode #(
    parameter int          NBANKS    = 4,
    parameter int          BANK_W    = 2,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic [63:0]       dstaddr,
    input  logic [7:0]        opcode,
    output logic [BANK_W-1:0] bank,
    output logic              sel_in,
    output logic              in_range,
    output logic              is_read,
    output logic              is_write,
    output logic              reject
);

    logic [63:0] off;

    // Addresses below the base wrap to huge offsets and fall out of range.
    assign off      = dstaddr - BASE_ADDR;
    assign in_range = (off < 64'(REG_STRIDE * NBANKS));
    assign sel_in   = off[3];
    assign bank     = off[4 +: BANK_W];
    assign is_read  = (opcode == UMI_READ_REQUEST);
    assign is_write = (opcode == UMI_WRITE_POSTED);
    assign reject   = !in_range || !(is_read || is_write) || (is_write && sel_in);

endmodule

// File: rtl/umi_gpio_bank.sv
// Multi-bank GPIO endpoint on a UMI request/response port pair.
// Build option UMI_GPIO_BANK_SYNC_EN adds a 2-flop synchronizer on gpio_in.
import umi_gpio_pkg::*;

module umi_gpio_bank #(
    parameter int          NBANKS    = 4,
    parameter int          RWIDTH    = 32,
    parameter int          WWIDTH    = 32,
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter logic [63:0] OUT_RESET = 64'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NBANKS*RWIDTH-1:0] gpio_in,
    output logic [NBANKS*WWIDTH-1:0] gpio_out,
    output logic [255:0]             umi_out_packet,
    output logic                     umi_out_valid,
    input  logic                     umi_out_ready,
    input  logic [255:0]             umi_in_packet,
    input  logic                     umi_in_valid,
    output logic                     umi_in_ready,
    output logic [15:0]              err_count
);

    localparam int BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1;
    localparam int WBYTES = WWIDTH / 8;

    gpio_state_t              state, state_nxt;
    umi_pkt_t                 req;
    umi_pkt_t                 rsp_pkt;
    logic [BANK_W-1:0]        bank;
    logic                     sel_in, in_range, is_read, is_write, reject;
    logic                     accept, wr_en, rsp_load, rsp_done;
    int                       wr_bytes;
    logic [WWIDTH-1:0]        out_q [NBANKS];
    logic [NBANKS*RWIDTH-1:0] pins;
    logic [63:0]              rd_word;
    logic [63:0]              rsp_dst_p1, rsp_data_p1;
    logic [2:0]               rsp_size_p1;
    logic                     vld_p1;
    logic [15:0]              err_q;

    assign req = umi_unpack(umi_in_packet);

    umi_gpio_decode #(
        .NBANKS    (NBANKS),
        .BANK_W    (BANK_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .dstaddr  (req.dstaddr),
        .opcode   (req.opcode),
        .bank     (bank),
        .sel_in   (sel_in),
        .in_range (in_range),
        .is_read  (is_read),
        .is_write (is_write),
        .reject   (reject)
    );

    assign umi_in_ready = (state == IDLE);
    assign accept       = umi_in_valid && umi_in_ready;
    assign wr_en        = accept && is_write && !reject;
    // Rejected reads still answer (with zero data) so the requester never stalls.
    assign rsp_load     = accept && is_read;
    assign rsp_done     = vld_p1 && umi_out_ready;
    assign wr_bytes     = umi_byte_count(req.size, WBYTES);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rsp_load) state_nxt = RESP;
            RESP:    if (rsp_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef UMI_GPIO_BANK_SYNC_EN
    logic [NBANKS*RWIDTH-1:0] sync_p0, sync_p1;

    // Stage 0/1: two-flop synchronizer on the input pins
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= gpio_in;
            sync_p1 <= sync_p0;
        end
    end
    assign pins = sync_p1;
`else
    assign pins = gpio_in;
`endif

    always_comb begin
        rd_word = '0;
        if (!reject) begin
            if (sel_in) rd_word[RWIDTH-1:0] = pins[int'(bank)*RWIDTH +: RWIDTH];
            else        rd_word[WWIDTH-1:0] = out_q[bank];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NBANKS; k++) out_q[k] <= OUT_RESET[WWIDTH-1:0];
        end else if (wr_en) begin
            for (int b = 0; b < WBYTES; b++) begin
                if (b < wr_bytes) out_q[bank][b*8 +: 8] <= req.data[b*8 +: 8];
            end
        end
    end

    for (genvar k = 0; k < NBANKS; k++) begin : g_out
        assign gpio_out[k*WWIDTH +: WWIDTH] = out_q[k];
    end

    // Stage 1: captured read response, held until the consumer takes it
    always_ff @(posedge clk) begin
        if (rst)           vld_p1 <= 1'b0;
        else if (rsp_load) vld_p1 <= 1'b1;
        else if (rsp_done) vld_p1 <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rsp_load) begin
            rsp_dst_p1  <= req.srcaddr;
            rsp_size_p1 <= req.size;
            rsp_data_p1 <= rd_word;
        end
    end

    always_comb begin
        rsp_pkt         = '0;
        rsp_pkt.opcode  = UMI_WRITE_RESPONSE;
        rsp_pkt.size    = rsp_size_p1;
        rsp_pkt.dstaddr = rsp_dst_p1;
        rsp_pkt.srcaddr = '0;
        rsp_pkt.data    = rsp_data_p1;
    end

    assign umi_out_packet = umi_pack(rsp_pkt);
    assign umi_out_valid  = vld_p1;

    always_ff @(posedge clk) begin
        if (rst)                                   err_q <= '0;
        else if (accept && reject && err_q != ERR_MAX) err_q <= err_q + 16'd1;
    end

    assign err_count = err_q;

endmodule

// File: tb/tb_umi_gpio_bank.sv
// Directed testbench for umi_gpio_bank: register writes, reads, stalls, rejects and reset.
module tb_umi_gpio_bank;

    localparam logic [63:0] BASE = 64'h0000_0000_0001_0000;
    localparam logic [31:0] ORST = 32'h1234_5678;
    localparam logic [7:0]  OP_WP   = 8'h01;
    localparam logic [7:0]  OP_RESP = 8'h02;
    localparam logic [7:0]  OP_RD   = 8'h08;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] gpio_in, gpio_out;
    logic [255:0] out_pkt, in_pkt, held;
    logic         out_valid, out_ready, in_valid, in_ready;
    logic [15:0]  err_count;
    logic [31:0]  exp_out [4];
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    umi_gpio_bank #(
        .NBANKS    (4),
        .RWIDTH    (32),
        .WWIDTH    (32),
        .BASE_ADDR (BASE),
        .OUT_RESET ({32'h0, ORST})
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .gpio_in        (gpio_in),
        .gpio_out       (gpio_out),
        .umi_out_packet (out_pkt),
        .umi_out_valid  (out_valid),
        .umi_out_ready  (out_ready),
        .umi_in_packet  (in_pkt),
        .umi_in_valid   (in_valid),
        .umi_in_ready   (in_ready),
        .err_count      (err_count)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mkpkt(input logic [7:0] op, input logic [2:0] size,
                                           input logic [63:0] dst, input logic [63:0] src,
                                           input logic [63:0] data);
        logic [255:0] p;
        p          = '0;
        p[7:0]     = op;
        p[10:8]    = size;
        p[95:32]   = dst;
        p[159:96]  = src;
        p[223:160] = data;
        return p;
    endfunction

    function automatic logic [127:0] exp_gpio();
        return {exp_out[3], exp_out[2], exp_out[1], exp_out[0]};
    endfunction

    task automatic send(input logic [7:0] op, input logic [2:0] size, input logic [63:0] dst,
                        input logic [63:0] src, input logic [63:0] data);
        in_pkt   = mkpkt(op, size, dst, src, data);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_resp(input string tag, input logic [63:0] dst, input logic [63:0] data,
                              input logic [2:0] size);
        check({tag, ".valid"}, 256'(out_valid), 256'(1'b1));
        check({tag, ".op"},    256'(out_pkt[7:0]), 256'(OP_RESP));
        check({tag, ".size"},  256'(out_pkt[10:8]), 256'(size));
        check({tag, ".dst"},   256'(out_pkt[95:32]), 256'(dst));
        check({tag, ".src"},   256'(out_pkt[159:96]), 256'(0));
        check({tag, ".data"},  256'(out_pkt[223:160]), 256'(data));
    endtask

    task automatic finish_resp(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".cleared"}, 256'(out_valid), 256'(1'b0));
        check({tag, ".ready"},   256'(in_ready), 256'(1'b1));
    endtask

    initial begin
        rst       = 1'b1;
        gpio_in   = '0;
        in_pkt    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) exp_out[k] = ORST;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst.valid", 256'(out_valid), 256'(1'b0));
        check("rst.ready", 256'(in_ready), 256'(1'b1));
        check("rst.err",   256'(err_count), 256'(0));
        check("rst.gpio",  256'(gpio_out), 256'(exp_gpio()));

        // Read OUT bank 2: response valid right after the accepting edge.
        send(OP_RD, 3'd2, BASE + 64'h20, 64'h1000, 64'h0);
        check("rd2.in_ready", 256'(in_ready), 256'(1'b0));
        check_resp("rd2", 64'h1000, 64'(ORST), 3'd2);

        // Stall the response with a write waiting; it must not be taken.
        held     = out_pkt;
        in_pkt   = mkpkt(OP_WP, 3'd2, BASE, 64'h0, 64'hCAFE_F00D);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("stall.ready", 256'(in_ready), 256'(1'b0));
            check("stall.pkt",   out_pkt, held);
        end
        check("stall.gpio", 256'(gpio_out), 256'(exp_gpio()));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("done.valid", 256'(out_valid), 256'(1'b0));
        check("done.gpio",  256'(gpio_out), 256'(exp_gpio()));
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        exp_out[0] = 32'hCAFE_F00D;
        check("late.gpio", 256'(gpio_out), 256'(exp_gpio()));

        // Byte-granular writes to bank 1.
        send(OP_WP, 3'd2, BASE + 64'h10, 64'h0, 64'hDEAD_BEEF);
        exp_out[1] = 32'hDEAD_BEEF;
        check("wr.size2", 256'(gpio_out), 256'(exp_gpio()));
        send(OP_WP, 3'd0, BASE + 64'h10, 64'h0, 64'h55);
        exp_out[1] = 32'hDEAD_BE55;
        check("wr.size0", 256'(gpio_out), 256'(exp_gpio()));
        send(OP_WP, 3'd3, BASE + 64'h10, 64'h0, 64'h1122_3344_AABB_CCDD);
        exp_out[1] = 32'hAABB_CCDD;
        check("wr.size3clamp", 256'(gpio_out), 256'(exp_gpio()));
        send(OP_WP, 3'd1, BASE + 64'h10, 64'h0, 64'hFFFF_9876);
        exp_out[1] = 32'hAABB_9876;
        check("wr.size1", 256'(gpio_out), 256'(exp_gpio()));

        // Read IN bank 3 after the pins have settled.
        gpio_in[3*32 +: 32] = 32'hA5A5_A5A5;
        repeat (3) @(posedge clk);
        #1;
        send(OP_RD, 3'd2, BASE + 64'h38, 64'h2000, 64'h0);
        check_resp("rdin3", 64'h2000, 64'hA5A5_A5A5, 3'd2);
        finish_resp("rdin3");

`ifdef UMI_GPIO_BANK_SYNC_EN
        // Pin change too recent to reach the second synchronizer stage.
        gpio_in[3*32 +: 32] = 32'h0F0F_0F0F;
        @(posedge clk);
        #1;
        send(OP_RD, 3'd2, BASE + 64'h38, 64'h2100, 64'h0);
        check_resp("sync.old", 64'h2100, 64'hA5A5_A5A5, 3'd2);
        finish_resp("sync.old");
        gpio_in[3*32 +: 32] = 32'h3C3C_3C3C;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        send(OP_RD, 3'd2, BASE + 64'h38, 64'h2200, 64'h0);
        check_resp("sync.new", 64'h2200, 64'h3C3C_3C3C, 3'd2);
        finish_resp("sync.new");
`else
        gpio_in[3*32 +: 32] = 32'h3C3C_3C3C;
        send(OP_RD, 3'd2, BASE + 64'h3F, 64'h2200, 64'h0);
        check_resp("direct.new", 64'h2200, 64'h3C3C_3C3C, 3'd2);
        finish_resp("direct.new");
`endif

        // Low address bits are ignored: 0x34 is still OUT bank 3.
        send(OP_RD, 3'd2, BASE + 64'h34, 64'h2300, 64'h0);
        check_resp("rdout3", 64'h2300, 64'(ORST), 3'd2);
        finish_resp("rdout3");

        // Rejected requests.
        send(OP_WP, 3'd2, BASE + 64'h18, 64'h0, 64'hFFFF_FFFF);
        check("rej.in.err",  256'(err_count), 256'(1));
        send(OP_WP, 3'd2, BASE + 64'h40, 64'h0, 64'hFFFF_FFFF);
        check("rej.oor.err", 256'(err_count), 256'(2));
        send(8'h7E, 3'd2, BASE, 64'h0, 64'hFFFF_FFFF);
        check("rej.op.err",   256'(err_count), 256'(3));
        check("rej.op.valid", 256'(out_valid), 256'(1'b0));
        check("rej.gpio",     256'(gpio_out), 256'(exp_gpio()));
        send(OP_RD, 3'd2, BASE + 64'h40, 64'h3000, 64'h0);
        check("rej.rd.err", 256'(err_count), 256'(4));
        check_resp("rej.rd", 64'h3000, 64'h0, 3'd2);
        finish_resp("rej.rd");
        send(OP_RD, 3'd1, BASE - 64'h10, 64'h3100, 64'h0);
        check("rej.below.err", 256'(err_count), 256'(5));
        check_resp("rej.below", 64'h3100, 64'h0, 3'd1);
        finish_resp("rej.below");

        // Reset while a response is pending.
        send(OP_RD, 3'd2, BASE + 64'h10, 64'h4000, 64'h0);
        check_resp("prerst", 64'h4000, 64'hAABB_9876, 3'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) exp_out[k] = ORST;
        check("midrst.valid", 256'(out_valid), 256'(1'b0));
        check("midrst.ready", 256'(in_ready), 256'(1'b1));
        check("midrst.err",   256'(err_count), 256'(0));
        check("midrst.gpio",  256'(gpio_out), 256'(exp_gpio()));

        send(OP_RD, 3'd2, BASE + 64'h10, 64'h5000, 64'h0);
        check_resp("postrst", 64'h5000, 64'(ORST), 3'd2);
        finish_resp("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
